// File: rtl/seq_multiplier.sv
// Purpose: multi-cycle shift-add multiplier, per-operand run-time signedness, PW=2*W product.
// Latency: Start accepted at edge t -> done pulse and new dout after edge t+W+1 (W+2 edges).
// Backpressure: Start is ignored while busy (no queueing); dout holds until the next done.
module seq_multiplier #(
  parameter  int W  = 4,
  localparam int PW = 2 * W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Start,
  input  logic          sign0,
  input  logic          sign1,
  input  logic [W-1:0]  din0,
  input  logic [W-1:0]  din1,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] dout
);

  // Counter must reach W-1 for every legal W.
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   mcand;
  logic [W-1:0]    mplier;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic            neg;

  logic [W-1:0]    mag0;
  logic [W-1:0]    mag1;
  logic            neg0;
  logic            neg1;

  // Operand magnitudes; the most negative value maps to 2^(W-1), which fits unsigned W bits.
  always_comb begin
    neg0 = sign0 & din0[W-1];
    neg1 = sign1 & din1[W-1];
    mag0 = neg0 ? (~din0 + 1'b1) : din0;
    mag1 = neg1 ? (~din1 + 1'b1) : din1;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> CALC for exactly W edges -> FIN -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (Start) state_nxt = CALC;
      CALC: if (cnt == CW'(W - 1)) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Datapath: latch magnitudes on accept, shift-add in CALC, apply sign and publish in FIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      dout   <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            mcand  <= {{W{1'b0}}, mag0};
            mplier <= mag1;
            neg    <= neg0 ^ neg1;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        FIN: begin
          // Negating a zero accumulator yields zero, so no negative zero can appear.
          dout <= neg ? (~acc + 1'b1) : acc;
          done <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: W=4 and W=8 instances sharing clock and reset.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// Expected products are hand-computed constants.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst;

  logic        start4, s0_4, s1_4;
  logic [3:0]  a4, b4;
  logic        busy4, done4;
  logic [7:0]  dout4;

  logic        start8, s0_8, s1_8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] dout8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.W(4)) u4 (
    .clk(clk), .rst(rst), .Start(start4), .sign0(s0_4), .sign1(s1_4),
    .din0(a4), .din1(b4), .busy(busy4), .done(done4), .dout(dout4)
  );

  seq_multiplier #(.W(8)) u8 (
    .clk(clk), .rst(rst), .Start(start8), .sign0(s0_8), .sign1(s1_8),
    .din0(a8), .din1(b8), .busy(busy8), .done(done8), .dout(dout8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete W=4 operation from a single-cycle Start pulse, checking timing and result.
  task automatic op4(input string tag, input logic s0, input logic s1,
                     input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
    s0_4 = s0; s1_4 = s1; a4 = a; b4 = b; start4 = 1'b1;
    step();
    start4 = 1'b0;
    check({tag, " busy_after_accept"}, 32'(busy4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check({tag, " busy_calc"}, 32'(busy4), 32'd1);
      check({tag, " done_early"}, 32'(done4), 32'd0);
    end
    step();
    check({tag, " done"}, 32'(done4), 32'd1);
    check({tag, " busy_at_done"}, 32'(busy4), 32'd0);
    check({tag, " dout"}, 32'(dout4), 32'(exp));
    step();
    check({tag, " done_one_cycle"}, 32'(done4), 32'd0);
    check({tag, " dout_held"}, 32'(dout4), 32'(exp));
  endtask

  initial begin
    rst = 1'b1;
    start4 = 1'b0; s0_4 = 1'b0; s1_4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; s0_8 = 1'b0; s1_8 = 1'b0; a8 = '0; b8 = '0;
    #12;
    check("reset busy4", 32'(busy4), 32'd0);
    check("reset done4", 32'(done4), 32'd0);
    check("reset dout4", 32'(dout4), 32'd0);
    check("reset dout8", 32'(dout8), 32'd0);
    rst = 1'b0;
    step();

    // 15 x -8 = -120, then the boundary products.
    op4("u15xs-8", 1'b0, 1'b1, 4'hF, 4'h8, 8'h88);
    op4("s-8xs-8", 1'b1, 1'b1, 4'h8, 4'h8, 8'h40);
    op4("u15xu15", 1'b0, 1'b0, 4'hF, 4'hF, 8'hE1);
    op4("s0xs-5",  1'b1, 1'b1, 4'h0, 4'hB, 8'h00);

    // Start two cycles into an operation is ignored; first result (3x5=15) still lands on time.
    s0_4 = 1'b0; s1_4 = 1'b0; a4 = 4'h3; b4 = 4'h5; start4 = 1'b1;
    step();                                  // edge t: accepted
    start4 = 1'b0;
    step();                                  // edge t+1
    a4 = 4'h7; b4 = 4'h7; start4 = 1'b1;
    step();                                  // edge t+2: ignored
    start4 = 1'b0;
    check("ign busy", 32'(busy4), 32'd1);
    step();                                  // edge t+3
    step();                                  // edge t+4 -> FIN
    check("ign busy_fin", 32'(busy4), 32'd1);
    check("ign done_early", 32'(done4), 32'd0);
    step();                                  // edge t+5
    check("ign done", 32'(done4), 32'd1);
    check("ign dout", 32'(dout4), 32'h0F);
    for (int i = 0; i < 8; i++) begin
      step();
      check("ign no_second_done", 32'(done4), 32'd0);
      check("ign idle", 32'(busy4), 32'd0);
    end
    check("ign dout_held", 32'(dout4), 32'h0F);

    // Start held high: one result every W+2 cycles, dout held in between.
    begin
      logic       bs0 [3];
      logic       bs1 [3];
      logic [3:0] ba  [3];
      logic [3:0] bb  [3];
      logic [7:0] bexp[3];
      logic [7:0] prev;
      bs0[0] = 1'b0; bs1[0] = 1'b0; ba[0] = 4'hF; bb[0] = 4'hF; bexp[0] = 8'hE1;  // 225
      bs0[1] = 1'b1; bs1[1] = 1'b1; ba[1] = 4'h7; bb[1] = 4'hF; bexp[1] = 8'hF9;  // 7 x -1
      bs0[2] = 1'b1; bs1[2] = 1'b0; ba[2] = 4'h8; bb[2] = 4'hF; bexp[2] = 8'h88;  // -8 x 15
      prev = 8'h0F;
      start4 = 1'b1;
      for (int k = 0; k < 3; k++) begin
        s0_4 = bs0[k]; s1_4 = bs1[k]; a4 = ba[k]; b4 = bb[k];
        step();                              // accept edge
        check("b2b busy", 32'(busy4), 32'd1);
        for (int i = 0; i < 4; i++) begin
          step();
          check("b2b done_early", 32'(done4), 32'd0);
          check("b2b dout_hold", 32'(dout4), 32'(prev));
        end
        step();
        check("b2b done", 32'(done4), 32'd1);
        check("b2b dout", 32'(dout4), 32'(bexp[k]));
        prev = bexp[k];
      end
      start4 = 1'b0;
      step();
      check("b2b final_idle", 32'(busy4), 32'd0);
      check("b2b final_done_low", 32'(done4), 32'd0);
      check("b2b final_hold", 32'(dout4), 32'h88);
    end

    // Asynchronous reset in the middle of CALC aborts the operation.
    s0_4 = 1'b0; s1_4 = 1'b0; a4 = 4'h3; b4 = 4'h3; start4 = 1'b1;
    step();
    start4 = 1'b0;
    step();
    step();
    #3;
    rst = 1'b1;
    #1;
    check("arst busy", 32'(busy4), 32'd0);
    check("arst done", 32'(done4), 32'd0);
    check("arst dout", 32'(dout4), 32'd0);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("arst no_done", 32'(done4), 32'd0);
      check("arst idle", 32'(busy4), 32'd0);
    end
    op4("post_rst s-3xs5", 1'b1, 1'b1, 4'hD, 4'h5, 8'hF1);   // -15

    // W=8: -128 x 127 = -16256, done after 10 edges.
    s0_8 = 1'b1; s1_8 = 1'b1; a8 = 8'h80; b8 = 8'h7F; start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("w8 done_early", 32'(done8), 32'd0);
    end
    check("w8 busy_fin", 32'(busy8), 32'd1);
    step();
    check("w8 done", 32'(done8), 32'd1);
    check("w8 dout", 32'(dout8), 32'hC080);
    step();
    check("w8 done_one_cycle", 32'(done8), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
